// File: rtl/syncro_pkg.sv
// Shared helpers for the filtered multi-channel bus synchroniser.
// Holds the counter-width calculation and the channel-slice offset helper
// used by syncro_filt_ch and syncro_filt_multi.
package syncro_pkg;

    localparam int SYNC_STAGES_DEF   = 3;
    localparam int STABLE_CYCLES_DEF = 2;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Stability counter width: must hold 0..stable_cycles without wrapping.
    // Never narrower than one bit so the port/reg is always legal.
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles < 1) ? 1 : clog2(stable_cycles + 1);
    endfunction

    // Low bit of channel ch in a flat NCH*WIDTH bus: bus[ch_lo(ch, w) +: w].
    function automatic int ch_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/syncro_filt_ch.sv
// One channel: SYNC_STAGES-deep synchroniser, stability filter and output register.
// Latency: sig_out updates SYNC_STAGES+1+STABLE_CYCLES edges after capture into the first flop.
// No backpressure; hold freezes every register and suppresses upd.
//
// Ports: clk_clkin/reset_n (sync, active-low), hold, sig_in (async word),
//        sig_out (filtered word), upd (registered strobe), upd_next (its D input).
module syncro_filt_ch
    import syncro_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk_clkin,
    input  logic             reset_n,
    input  logic             hold,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic             upd,
    output logic             upd_next
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] last;

    always_ff @(posedge clk_clkin) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else if (!hold) begin
            sync_q[0] <= sig_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign last = sync_q[SYNC_STAGES-1];

    if (STABLE_CYCLES == 0) begin : g_nofilt

        always_comb begin
            upd_next = !hold && (last != sig_out);
        end

        always_ff @(posedge clk_clkin) begin
            if (!reset_n) begin
                sig_out <= '0;
                upd     <= 1'b0;
            end else begin
                upd <= upd_next;
                if (!hold) begin
                    sig_out <= last;
                end
            end
        end

    end else begin : g_filt

        localparam int CNT_W = cnt_width(STABLE_CYCLES);
        localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

        logic [WIDTH-1:0] stab;
        logic [CNT_W-1:0] cnt;
        logic             accept;

        // accept: this edge completes a run of STABLE_CYCLES matching samples.
        always_comb begin
            accept   = !hold && (last == stab) && (cnt == CNT_LAST);
            upd_next = accept && (last != sig_out);
        end

        always_ff @(posedge clk_clkin) begin
            if (!reset_n) begin
                stab    <= '0;
                cnt     <= '0;
                sig_out <= '0;
                upd     <= 1'b0;
            end else begin
                upd <= upd_next;
                if (!hold) begin
                    stab <= last;
                    if (last != stab) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Saturate so a long-stable value never re-triggers.
                        cnt     <= CNT_MAX;
                        sig_out <= last;
                    end else if (cnt < CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

    end

endmodule

// File: rtl/syncro_filt_multi.sv
// NCH independent filtered synchronisers into clk_clkin, plus a registered any-update flag.
// Latency: SYNC_STAGES+1+STABLE_CYCLES edges from capture to sig_out; any_upd aligned with upd.
// No backpressure; hold freezes all state and forces upd/any_upd low.
//
// Ports: clk_clkin, reset_n (sync, active-low), hold, sig_in[NCH*WIDTH] (async),
//        sig_out[NCH*WIDTH], upd[NCH], any_upd.
module syncro_filt_multi
    import syncro_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int NCH           = 2,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic                 clk_clkin,
    input  logic                 reset_n,
    input  logic                 hold,
    input  logic [NCH*WIDTH-1:0] sig_in,
    output logic [NCH*WIDTH-1:0] sig_out,
    output logic [NCH-1:0]       upd,
    output logic                 any_upd
);

    logic [NCH-1:0] upd_next;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        syncro_filt_ch #(
            .WIDTH         (WIDTH),
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk_clkin (clk_clkin),
            .reset_n   (reset_n),
            .hold      (hold),
            .sig_in    (sig_in[ch_lo(c, WIDTH) +: WIDTH]),
            .sig_out   (sig_out[ch_lo(c, WIDTH) +: WIDTH]),
            .upd       (upd[c]),
            .upd_next  (upd_next[c])
        );
    end

    // Built from the per-channel D inputs so it lands in the same cycle as upd.
    always_ff @(posedge clk_clkin) begin
        if (!reset_n) begin
            any_upd <= 1'b0;
        end else begin
            any_upd <= |upd_next;
        end
    end

endmodule

// File: tb/tb_syncro_filt_multi.sv
module tb_syncro_filt_multi;

    typedef struct {
        logic [31:0] val;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hold;
    logic        hold2;
    logic [63:0] sig_in;
    logic [63:0] sig_in2;
    logic [63:0] sig_out;
    logic [63:0] sig_out2;
    logic [1:0]  upd;
    logic [1:0]  upd2;
    logic        any_upd;
    logic        any_upd2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Expected strobes: 0 = dut ch0, 1 = dut ch1, 2 = dut2 ch1, 3 = dut2 ch0.
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    syncro_filt_multi dut (
        .clk_clkin (clk),
        .reset_n   (reset_n),
        .hold      (hold),
        .sig_in    (sig_in),
        .sig_out   (sig_out),
        .upd       (upd),
        .any_upd   (any_upd)
    );

    syncro_filt_multi #(
        .WIDTH         (32),
        .NCH           (2),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (0)
    ) dut2 (
        .clk_clkin (clk),
        .reset_n   (reset_n),
        .hold      (hold2),
        .sig_in    (sig_in2),
        .sig_out   (sig_out2),
        .upd       (upd2),
        .any_upd   (any_upd2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the next expected entry.
    always @(negedge clk) begin
        for (int s = 0; s < 4; s++) begin
            logic        u;
            logic        a;
            logic        have;
            logic [31:0] v;
            exp_t        e;
            u = 1'b0; a = 1'b0; have = 1'b0; v = '0;
            e.val = '0; e.at = 0;
            case (s)
                0: begin u = upd[0];  v = sig_out[31:0];   a = any_upd;  end
                1: begin u = upd[1];  v = sig_out[63:32];  a = any_upd;  end
                2: begin u = upd2[1]; v = sig_out2[63:32]; a = any_upd2; end
                default: begin u = upd2[0]; v = sig_out2[31:0]; a = any_upd2; end
            endcase
            if (u === 1'b1) begin
                case (s)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                    default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
                endcase
                checks++;
                if (have !== 1'b1) begin
                    fails++;
                    $display("FAIL unexpected_upd stream %0d: got strobe with value %h at cycle %0d, required no strobe", s, v, cyc);
                end else begin
                    checks++;
                    if (v !== e.val) begin
                        fails++;
                        $display("FAIL upd_value stream %0d: got %h, required %h", s, v, e.val);
                    end
                    checks++;
                    if (cyc !== e.at) begin
                        fails++;
                        $display("FAIL upd_cycle stream %0d: got cycle %0d, required %0d", s, cyc, e.at);
                    end
                    checks++;
                    if (a !== 1'b1) begin
                        fails++;
                        $display("FAIL any_upd stream %0d: got %b, required 1", s, a);
                    end
                end
            end
        end
    end

    task automatic push_exp(input int s, input logic [31:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        case (s)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        int left;
        left = q0.size() + q1.size() + q2.size() + q3.size();
        checks++;
        if (left !== 0) begin
            fails++;
            $display("FAIL %s_drained: got %0d outstanding strobes, required 0", name, left);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hold = 1'b0; hold2 = 1'b0;
        sig_in  = '1;
        sig_in2 = '0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (sig_out !== 64'h0 || upd !== 2'b00 || any_upd !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: got sig_out=%h upd=%b any_upd=%b, required all 0", sig_out, upd, any_upd);
            end
        end
        sig_in  = {32'h0, 32'h0000_00A5};
        reset_n = 1'b1;
        push_exp(0, 32'h0000_00A5, cyc + 6);
        wait_cycles(10);
        checks++;
        if (sig_out !== {32'h0, 32'h0000_00A5}) begin
            fails++;
            $display("FAIL reset_release: got %h, required %h", sig_out, {32'h0, 32'h0000_00A5});
        end
        check_drained("reset");
    endtask

    task automatic test_latency();
        sig_in[63:32]  = 32'h1234_5678;
        sig_in2[63:32] = 32'h1234_5678;
        push_exp(1, 32'h1234_5678, cyc + 6);
        push_exp(2, 32'h1234_5678, cyc + 3);
        wait_cycles(10);
        checks++;
        if (sig_out2[63:32] !== 32'h1234_5678) begin
            fails++;
            $display("FAIL latency_nofilt_value: got %h, required 12345678", sig_out2[63:32]);
        end
        check_drained("latency");
    endtask

    task automatic test_glitch();
        sig_in[31:0] = 32'h11;
        push_exp(0, 32'h11, cyc + 6);
        wait_cycles(10);
        // Two-cycle pulse: shorter than a full run, must be rejected.
        sig_in[31:0] = 32'h22;
        wait_cycles(2);
        sig_in[31:0] = 32'h11;
        wait_cycles(10);
        checks++;
        if (sig_out[31:0] !== 32'h11) begin
            fails++;
            $display("FAIL glitch_reject: got %h, required 11", sig_out[31:0]);
        end
        // Three-cycle pulse: long enough to be accepted, then reverts.
        sig_in[31:0] = 32'h22;
        push_exp(0, 32'h22, cyc + 6);
        push_exp(0, 32'h11, cyc + 9);
        wait_cycles(3);
        sig_in[31:0] = 32'h11;
        wait_cycles(10);
        checks++;
        if (sig_out[31:0] !== 32'h11) begin
            fails++;
            $display("FAIL glitch_accept_return: got %h, required 11", sig_out[31:0]);
        end
        check_drained("glitch");
    endtask

    task automatic test_hold();
        sig_in[31:0] = 32'h55;
        push_exp(0, 32'h55, cyc + 16);
        wait_cycles(5);
        hold = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (sig_out[31:0] !== 32'h11 || upd !== 2'b00 || any_upd !== 1'b0) begin
                fails++;
                $display("FAIL hold_freeze: got sig_out=%h upd=%b any_upd=%b, required 11/00/0", sig_out[31:0], upd, any_upd);
            end
        end
        hold = 1'b0;
        wait_cycles(5);
        check_drained("hold");
    endtask

    task automatic test_back_to_back();
        sig_in = {32'h5555_5555, 32'hAAAA_AAAA};
        push_exp(0, 32'hAAAA_AAAA, cyc + 6);
        push_exp(1, 32'h5555_5555, cyc + 6);
        wait_cycles(6);
        checks++;
        if (upd !== 2'b11 || any_upd !== 1'b1) begin
            fails++;
            $display("FAIL simultaneous: got upd=%b any_upd=%b, required 11/1", upd, any_upd);
        end
        wait_cycles(4);
        check_drained("simultaneous");
    endtask

    task automatic test_reset_mid();
        sig_in[31:0] = 32'h77;
        wait_cycles(5);
        checks++;
        if (sig_out[31:0] !== 32'hAAAA_AAAA) begin
            fails++;
            $display("FAIL reset_mid_pending: got %h, required aaaaaaaa", sig_out[31:0]);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (sig_out !== 64'h0 || upd !== 2'b00 || sig_out2 !== 64'h0) begin
            fails++;
            $display("FAIL reset_mid_clear: got sig_out=%h upd=%b sig_out2=%h, required 0", sig_out, upd, sig_out2);
        end
        reset_n = 1'b1;
        push_exp(0, 32'h77, cyc + 6);
        push_exp(1, 32'h5555_5555, cyc + 6);
        push_exp(2, 32'h1234_5678, cyc + 3);
        wait_cycles(10);
        checks++;
        if (sig_out !== {32'h5555_5555, 32'h0000_0077}) begin
            fails++;
            $display("FAIL reset_mid_refilter: got %h, required 5555555500000077", sig_out);
        end
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
